// File: rtl/eclair_pkg.sv
// Shared constants for the eclair execution unit: ALU modes, op codes, widths.
package eclair_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int DMX_SEL_W      = 3;
   localparam int DMX_OUT_W      = 8;

   localparam logic ALU_ARITH = 1'b0;
   localparam logic ALU_LOGIC = 1'b1;

   // arithmetic-mode op codes (results shown before carry-in)
   localparam logic [3:0] OP_ARITH_A = 4'h0;  // A
   localparam logic [3:0] OP_ONES_AR = 4'h3;  // all ones
   localparam logic [3:0] OP_SUBM1   = 4'h6;  // A - B - 1
   localparam logic [3:0] OP_ADD     = 4'h9;  // A + B
   localparam logic [3:0] OP_DBL     = 4'hC;  // A + A
   localparam logic [3:0] OP_DEC     = 4'hF;  // A - 1

   // logic-mode op codes
   localparam logic [3:0] OP_NOT_A   = 4'h0;
   localparam logic [3:0] OP_NOR     = 4'h1;
   localparam logic [3:0] OP_NA_AND_B= 4'h2;
   localparam logic [3:0] OP_ZERO    = 4'h3;
   localparam logic [3:0] OP_NAND    = 4'h4;
   localparam logic [3:0] OP_NOT_B   = 4'h5;
   localparam logic [3:0] OP_XOR     = 4'h6;
   localparam logic [3:0] OP_A_AND_NB= 4'h7;
   localparam logic [3:0] OP_NA_OR_B = 4'h8;
   localparam logic [3:0] OP_XNOR    = 4'h9;
   localparam logic [3:0] OP_PASS_B  = 4'hA;
   localparam logic [3:0] OP_AND     = 4'hB;
   localparam logic [3:0] OP_ONES    = 4'hC;
   localparam logic [3:0] OP_A_OR_NB = 4'hD;
   localparam logic [3:0] OP_OR      = 4'hE;
   localparam logic [3:0] OP_PASS_A  = 4'hF;

endpackage

// File: rtl/eclair_exec_unit_if.sv
// Operand, control and result bundle between the sequencer and the execution unit.
interface eclair_exec_unit_if
   import eclair_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  alu_mode;
   logic [3:0]            alu_op;
   logic                  c_in;
   logic [DATA_WIDTH-1:0] x;
   logic [DATA_WIDTH-1:0] y;
   logic [DATA_WIDTH-1:0] alu_z;
   logic                  c_out;
   logic                  z_load;
   logic [DATA_WIDTH-1:0] reg_z;
   logic                  pc_inc;
   logic                  pc_load;
   logic [DATA_WIDTH-1:0] pc;
   logic                  dmx_en;
   logic [DMX_SEL_W-1:0]  dmx_sel;
   logic [DMX_OUT_W-1:0]  dmx_y;

   modport master (
      output alu_mode, alu_op, c_in, x, y, z_load, pc_inc, pc_load, dmx_en, dmx_sel,
      input  alu_z, c_out, reg_z, pc, dmx_y
   );

   modport slave (
      input  alu_mode, alu_op, c_in, x, y, z_load, pc_inc, pc_load, dmx_en, dmx_sel,
      output alu_z, c_out, reg_z, pc, dmx_y
   );
endinterface

// File: rtl/alu_181_core.sv
// Combinational '181-style ALU: arithmetic via P/Q generate terms, or 16 logic functions.
module alu_181_core
   import eclair_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  mode,
   input  logic [3:0]            op,
   input  logic                  c_in,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] z,
   output logic                  c_out
);

   logic [DATA_WIDTH-1:0] s0, s1, s2, s3;
   logic [DATA_WIDTH-1:0] p, q;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] lz;

   assign s0 = {DATA_WIDTH{op[0]}};
   assign s1 = {DATA_WIDTH{op[1]}};
   assign s2 = {DATA_WIDTH{op[2]}};
   assign s3 = {DATA_WIDTH{op[3]}};

   // P and Q are chosen so that P + Q yields the arithmetic function for each op
   assign p   = a | (b & s0) | (~b & s1);
   assign q   = (a & b & s3) | (a & ~b & s2);
   assign sum = {1'b0, p} + {1'b0, q} + {{DATA_WIDTH{1'b0}}, c_in};

   // logic-mode function table; carry-in plays no part here
   always_comb begin
      lz = '0;
      case (op)
         OP_NOT_A:    lz = ~a;
         OP_NOR:      lz = ~(a | b);
         OP_NA_AND_B: lz = ~a & b;
         OP_ZERO:     lz = '0;
         OP_NAND:     lz = ~(a & b);
         OP_NOT_B:    lz = ~b;
         OP_XOR:      lz = a ^ b;
         OP_A_AND_NB: lz = a & ~b;
         OP_NA_OR_B:  lz = ~a | b;
         OP_XNOR:     lz = ~(a ^ b);
         OP_PASS_B:   lz = b;
         OP_AND:      lz = a & b;
         OP_ONES:     lz = '1;
         OP_A_OR_NB:  lz = a | ~b;
         OP_OR:       lz = a | b;
         OP_PASS_A:   lz = a;
         default:     lz = '0;
      endcase
   end

   assign z     = (mode == ALU_LOGIC) ? lz : sum[DATA_WIDTH-1:0];
   assign c_out = (mode == ALU_LOGIC) ? 1'b0 : sum[DATA_WIDTH];

endmodule

// File: rtl/eclair_exec_unit.sv
// Execution unit top: ALU core, Z register, program counter and 3-to-8 active-low demux.
module eclair_exec_unit
   import eclair_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input logic                clk,
   input logic                _reset,
   eclair_exec_unit_if.slave  bus
);

   logic [DATA_WIDTH-1:0] alu_z;
   logic [DATA_WIDTH-1:0] reg_z;
   logic [DATA_WIDTH-1:0] pc;

   alu_181_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .mode  (bus.alu_mode),
      .op    (bus.alu_op),
      .c_in  (bus.c_in),
      .a     (bus.x),
      .b     (bus.y),
      .z     (alu_z),
      .c_out (bus.c_out)
   );

   // Z register captures the ALU result on demand
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset)         reg_z <= '0;
      else if (bus.z_load) reg_z <= alu_z;
   end

   // PC: load from the pre-edge reg_z wins over increment; increment wraps silently
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset)          pc <= '0;
      else if (bus.pc_load) pc <= reg_z;
      else if (bus.pc_inc)  pc <= pc + 1'b1;
   end

   assign bus.alu_z = alu_z;
   assign bus.reg_z = reg_z;
   assign bus.pc    = pc;

   // one-cold decode, idle high; no reset involvement
   assign bus.dmx_y = bus.dmx_en ? (~(DMX_OUT_W'(1) << bus.dmx_sel)) : {DMX_OUT_W{1'b1}};

endmodule

// File: tb/tb_eclair_exec_unit.sv
// Directed bench for eclair_exec_unit: ALU vectors, Z/PC sequencing, reset, demux.
module tb_eclair_exec_unit;
   import eclair_pkg::*;

   logic clk;
   logic _reset;
   int   vec_cnt;
   int   err_cnt;

   eclair_exec_unit_if #(.DATA_WIDTH(16)) bus ();

   eclair_exec_unit #(.DATA_WIDTH(16)) dut (
      .clk    (clk),
      ._reset (_reset),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic alu_set(input logic m, input logic [3:0] op, input logic ci,
                          input logic [15:0] a, input logic [15:0] b);
      bus.alu_mode = m;
      bus.alu_op   = op;
      bus.c_in     = ci;
      bus.x        = a;
      bus.y        = b;
      #1;
   endtask

   task automatic alu_chk(input string tag, input logic m, input logic [3:0] op,
                          input logic ci, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ez, input logic ec);
      alu_set(m, op, ci, a, b);
      chk({tag, "_z"}, 32'(bus.alu_z), 32'(ez));
      chk({tag, "_c"}, 32'(bus.c_out), 32'(ec));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      _reset       = 1'b0;
      bus.alu_mode = 1'b0;
      bus.alu_op   = 4'h0;
      bus.c_in     = 1'b0;
      bus.x        = '0;
      bus.y        = '0;
      bus.z_load   = 1'b0;
      bus.pc_inc   = 1'b0;
      bus.pc_load  = 1'b0;
      bus.dmx_en   = 1'b0;
      bus.dmx_sel  = '0;
      #2;
      chk("rst_pc",   32'(bus.pc),    32'h0);
      chk("rst_regz", 32'(bus.reg_z), 32'h0);
      chk("rst_dmx",  32'(bus.dmx_y), 32'hFF);

      // combinational ALU vectors
      alu_chk("add0",   ALU_ARITH, OP_ADD,   1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0);
      alu_chk("add1",   ALU_ARITH, OP_ADD,   1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
      alu_chk("sub",    ALU_ARITH, OP_SUBM1, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1);
      alu_chk("subm1",  ALU_ARITH, OP_SUBM1, 1'b0, 16'h0003, 16'h0005, 16'hFFFD, 1'b0);
      alu_chk("xor",    ALU_LOGIC, OP_XOR,   1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0);
      alu_chk("dbl",    ALU_ARITH, OP_DBL,   1'b0, 16'h8001, 16'h1234, 16'h0002, 1'b1);
      alu_chk("dec0",   ALU_ARITH, OP_DEC,   1'b0, 16'h0000, 16'h5555, 16'hFFFF, 1'b0);
      alu_chk("dec5",   ALU_ARITH, OP_DEC,   1'b0, 16'h0005, 16'h5555, 16'h0004, 1'b1);
      alu_chk("ones_a", ALU_ARITH, OP_ONES_AR,1'b0,16'h1234, 16'hABCD, 16'hFFFF, 1'b0);
      alu_chk("pass_a", ALU_ARITH, OP_ARITH_A,1'b1,16'h1234, 16'hABCD, 16'h1235, 1'b0);
      alu_chk("lzero",  ALU_LOGIC, OP_ZERO,  1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
      alu_chk("lnota",  ALU_LOGIC, OP_NOT_A, 1'b1, 16'h00FF, 16'h1234, 16'hFF00, 1'b0);
      alu_chk("lnor",   ALU_LOGIC, OP_NOR,   1'b0, 16'h00F0, 16'h000F, 16'hFF00, 1'b0);
      alu_chk("land",   ALU_LOGIC, OP_AND,   1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
      alu_chk("laonb",  ALU_LOGIC, OP_A_OR_NB,1'b0,16'h0001, 16'hFF00, 16'h00FF, 1'b0);

      // control during reset is ignored across an edge
      bus.z_load = 1'b1;
      bus.pc_inc = 1'b1;
      step();
      chk("rst_hold_pc", 32'(bus.pc), 32'h0);
      bus.z_load = 1'b0;

      // release between edges, then count three cycles
      _reset = 1'b1;
      repeat (3) step();
      chk("pc_cnt3", 32'(bus.pc), 32'h3);

      alu_set(ALU_LOGIC, OP_ONES, 1'b0, 16'h0000, 16'h0000);
      bus.pc_inc = 1'b0;
      bus.z_load = 1'b1;
      step();
      chk("zload_ffff", 32'(bus.reg_z), 32'hFFFF);
      chk("pc_hold",    32'(bus.pc),    32'h3);
      bus.z_load  = 1'b0;
      bus.pc_load = 1'b1;
      step();
      chk("pc_ld_ffff", 32'(bus.pc), 32'hFFFF);
      bus.pc_load = 1'b0;
      bus.pc_inc  = 1'b1;
      step();
      chk("pc_wrap", 32'(bus.pc), 32'h0);

      // build reg_z=0x0100, pc=5, then assert load and inc together
      alu_set(ALU_LOGIC, OP_PASS_B, 1'b0, 16'h0000, 16'h0100);
      bus.z_load = 1'b1;
      step();
      bus.z_load = 1'b0;
      repeat (4) step();
      chk("pc_5",     32'(bus.pc),    32'h5);
      chk("regz_100", 32'(bus.reg_z), 32'h0100);
      bus.pc_load = 1'b1;
      step();
      chk("pc_ld_pri", 32'(bus.pc), 32'h0100);

      // z_load and pc_load together: pc takes the old reg_z
      alu_set(ALU_LOGIC, OP_PASS_B, 1'b0, 16'h0000, 16'h0ABC);
      bus.z_load = 1'b1;
      step();
      chk("ld_both_pc", 32'(bus.pc),    32'h0100);
      chk("ld_both_z",  32'(bus.reg_z), 32'h0ABC);

      // count then reset between edges
      bus.z_load  = 1'b0;
      bus.pc_load = 1'b0;
      bus.pc_inc  = 1'b1;
      repeat (2) step();
      chk("pc_102", 32'(bus.pc), 32'h0102);
      #2;
      _reset = 1'b0;
      #1;
      chk("mid_rst_pc",   32'(bus.pc),    32'h0);
      chk("mid_rst_regz", 32'(bus.reg_z), 32'h0);
      chk("mid_rst_aluz", 32'(bus.alu_z), 32'h0ABC);
      bus.z_load = 1'b1;
      repeat (2) step();
      chk("rst_held_pc",   32'(bus.pc),    32'h0);
      chk("rst_held_regz", 32'(bus.reg_z), 32'h0);
      #2;
      _reset = 1'b1;
      step();
      chk("resume_pc",   32'(bus.pc),    32'h1);
      chk("resume_regz", 32'(bus.reg_z), 32'h0ABC);
      bus.z_load = 1'b0;
      bus.pc_inc = 1'b0;

      // demux
      bus.dmx_en  = 1'b1;
      bus.dmx_sel = 3'd5;
      #1;
      chk("dmx_5", 32'(bus.dmx_y), 32'hDF);
      bus.dmx_sel = 3'd0;
      #1;
      chk("dmx_0", 32'(bus.dmx_y), 32'hFE);
      bus.dmx_sel = 3'd7;
      #1;
      chk("dmx_7", 32'(bus.dmx_y), 32'h7F);
      bus.dmx_en = 1'b0;
      #1;
      chk("dmx_off", 32'(bus.dmx_y), 32'hFF);
      _reset     = 1'b0;
      bus.dmx_en = 1'b1;
      bus.dmx_sel = 3'd2;
      #1;
      chk("dmx_rst", 32'(bus.dmx_y), 32'hFB);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/eclair_exec_unit.md
ECLAIR_EXEC_UNIT -- requirements
Module: eclair_exec_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of ALU operands, Z register and PC.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port _reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port alu_mode, input, 1, 0=arithmetic, 1=logic.
REQ-005 SHALL have port alu_op, input, 4, ALU function select S[3:0].
REQ-006 SHALL have port c_in, input, 1, arithmetic carry-in, active-high (+1).
REQ-007 SHALL have ports x and y, input, 16 each, ALU operands A and B.
REQ-008 SHALL have port alu_z, output, 16, combinational ALU result.
REQ-009 SHALL have port c_out, output, 1, combinational carry-out.
REQ-010 SHALL have port z_load, input, 1, capture alu_z into reg_z.
REQ-011 SHALL have port reg_z, output, 16, Z register.
REQ-012 SHALL have ports pc_inc and pc_load, input, 1 each, PC increment and PC load-from-reg_z.
REQ-013 SHALL have port pc, output, 16, program counter.
REQ-014 SHALL have port dmx_en, input, 1, demux enable, active-high.
REQ-015 SHALL have port dmx_sel, input, 3, demux select.
REQ-016 SHALL have port dmx_y, output, 8, one-cold active-low decode.

Function
REQ-017 SHALL compute arithmetic mode (alu_mode=0) as {c_out,alu_z} = P + Q + c_in, 17-bit, with P = A | (B&S0) | (~B&S1) and Q = (A&B&S3) | (A&~B&S2).
REQ-018 SHALL thereby give, before c_in: S=0 A; 3 all-ones; 6 A-B-1; 9 A+B; C A+A; F A-1.
REQ-019 SHALL compute logic mode (alu_mode=1) per S: 0 ~A, 1 ~(A|B), 2 ~A&B, 3 0, 4 ~(A&B), 5 ~B, 6 A^B, 7 A&~B, 8 ~A|B, 9 ~(A^B), A B, B A&B, C all-ones, D A|~B, E A|B, F A.
REQ-020 SHALL hold c_out at 0 in logic mode, and SHALL ignore c_in in logic mode.
REQ-021 SHALL have alu_z and c_out settle within the same cycle, with zero-cycle latency and no registering.
REQ-022 SHALL load reg_z <= alu_z on a clk edge when z_load=1, and SHALL hold it otherwise.
REQ-023 SHALL load pc <= reg_z (value before the edge) when pc_load=1.
REQ-024 SHALL otherwise set pc <= pc+1 when pc_inc=1, and SHALL otherwise hold pc.
REQ-025 SHALL give pc_load priority over pc_inc when both are asserted.
REQ-026 SHALL wrap pc from 0xFFFF to 0x0000 on increment, with no flag.
REQ-027 SHALL load pc with the old reg_z when z_load and pc_load are asserted in the same cycle.
REQ-028 SHALL drive dmx_y[dmx_sel]=0 and all other bits 1 when dmx_en=1.
REQ-029 SHALL drive dmx_y=8'hFF when dmx_en=0.
REQ-030 SHALL keep dmx_y purely combinational and independent of reset.

Reset
REQ-031 SHALL clear pc and reg_z to 0x0000 immediately, without waiting for clk, while _reset=0.
REQ-032 SHALL ignore z_load, pc_inc and pc_load while _reset=0.
REQ-033 SHALL resume normal operation at the first clk edge after _reset rises, including when reset is asserted mid-count.
REQ-034 SHALL leave alu_z, c_out and dmx_y unaffected by reset.

Structure
REQ-035 SHALL place in shared package eclair_pkg: ALU mode constants (ALU_ARITH, ALU_LOGIC), named 4-bit op codes (OP_ADD=9, OP_SUBM1=6, OP_XOR=6, OP_PASS_A=F, etc.) and DATA_WIDTH default.
REQ-036 SHALL implement the combinational ALU as one sub-module, alu_181_core; PC, Z register and demux SHALL stay in the top level.

Verification
REQ-037 SHALL verify arithmetic add: mode 0, op 9, c_in 0, x 0x1234, y 0x0FFF -> alu_z 0x2233, c_out 0; x 0xFFFF, y 0x0001 -> alu_z 0x0000, c_out 1.
REQ-038 SHALL verify subtract and logic: mode 0, op 6, c_in 1, x 0x0005, y 0x0003 -> alu_z 0x0002, c_out 1; mode 1, op 6, x 0xF0F0, y 0xFF00 -> alu_z 0x0FF0, c_out 0.
REQ-039 SHALL verify PC counting: reset -> pc 0; pc_inc 3 cycles -> pc 3; z_load with alu_z 0xFFFF, then pc_load -> pc 0xFFFF; pc_inc -> pc 0x0000.
REQ-040 SHALL verify simultaneous controls: reg_z 0x0100, pc 0x0005, pc_load=pc_inc=1 -> pc 0x0100 next edge.
REQ-041 SHALL verify mid-operation reset: _reset low between edges while counting -> pc and reg_z 0x0000 before next edge; held through edges with pc_inc=1 -> stay 0.
REQ-042 SHALL verify demux: dmx_en 1, dmx_sel 5 -> dmx_y 8'b1101_1111; dmx_sel 0 -> 8'b1111_1110; dmx_en 0 -> 8'hFF.
